// File: rtl/queue_stream_arb_pkg.sv
// Shared width helpers and stored-entry layout for the queue stream arbiter.
package queue_stream_arb_pkg;

  function automatic int chan_bits(input int n_chan);
    return (n_chan <= 1) ? 1 : $clog2(n_chan);
  endfunction

  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Entry shape for the default 64-bit payload; the FIFO builds the same shape around QTYPE.
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } entry_t;

endpackage

// File: rtl/queue_stream_fifo.sv
// Single-channel first-word-fall-through FIFO; head entry is visible combinationally.
module queue_stream_fifo
  import queue_stream_arb_pkg::*;
#(
  parameter type QTYPE    = logic [63:0],
  parameter int  QDEPTH   = 8,
  localparam int CNT_BITS = cnt_bits(QDEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  QTYPE                push_data,
  input  logic                push_last,
  input  logic                pop,
  output QTYPE                head_data,
  output logic                head_last,
  output logic                empty,
  output logic                rdy,
  output logic [CNT_BITS-1:0] cnt
);

  localparam int AW = $clog2(QDEPTH);

  typedef struct packed {
    QTYPE data;
    logic last;
  } fifo_entry_t;

  fifo_entry_t         mem [QDEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CNT_BITS-1:0] count;

  assign rdy       = count < CNT_BITS'(QDEPTH);
  assign empty     = count == '0;
  assign head_data = mem[rd_ptr].data;
  assign head_last = mem[rd_ptr].last;
  assign cnt       = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CNT_BITS'(1);
      else if (!push && pop) count <= count - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: push_data, last: push_last};
  end

endmodule

// File: rtl/queue_stream_arb.sv
// Round-robin merge of N_CHAN FIFO-buffered streams into one registered output stream.
// Define QUEUE_STREAM_ARB_PKT_EN to hold a grant until the packet's last word is popped.
module queue_stream_arb
  import queue_stream_arb_pkg::*;
#(
  parameter type QTYPE     = logic [63:0],
  parameter int  QDEPTH    = 8,
  parameter int  N_CHAN    = 4,
  localparam int CHAN_BITS = chan_bits(N_CHAN),
  localparam int CNT_BITS  = cnt_bits(QDEPTH)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [N_CHAN-1:0]    val_snk,
  output logic [N_CHAN-1:0]    rdy_snk,
  input  QTYPE                 data_snk [N_CHAN],
  input  logic [N_CHAN-1:0]    last_snk,
  output logic                 val_src,
  input  logic                 rdy_src,
  output QTYPE                 data_src,
  output logic [CHAN_BITS-1:0] id_src,
  output logic                 last_src,
  output logic [CNT_BITS-1:0]  cnt [N_CHAN]
);

  QTYPE                 head_data [N_CHAN];
  logic [N_CHAN-1:0]    head_last;
  logic [N_CHAN-1:0]    empty;
  logic [N_CHAN-1:0]    pop;
  logic [CHAN_BITS-1:0] rr;
  logic [CHAN_BITS-1:0] gnt;
  logic [CHAN_BITS-1:0] idx;
  logic                 gnt_vld;
  logic                 load;
  logic                 take;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    queue_stream_fifo #(
      .QTYPE  (QTYPE),
      .QDEPTH (QDEPTH)
    ) u_fifo (
      .clk       (aclk),
      .rst       (areset),
      .push      (val_snk[i] & rdy_snk[i]),
      .push_data (data_snk[i]),
      .push_last (last_snk[i]),
      .pop       (pop[i]),
      .head_data (head_data[i]),
      .head_last (head_last[i]),
      .empty     (empty[i]),
      .rdy       (rdy_snk[i]),
      .cnt       (cnt[i])
    );
  end

`ifdef QUEUE_STREAM_ARB_PKT_EN
  logic lock;
`endif

  // rr holds the last granted channel; search begins one past it.
  always_comb begin
    gnt     = rr;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_CHAN; i++) begin
      idx = CHAN_BITS'((int'(rr) + i) % N_CHAN);
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
`ifdef QUEUE_STREAM_ARB_PKT_EN
    if (lock) begin
      gnt     = rr;
      gnt_vld = !empty[rr];
    end
`endif
  end

  assign load = !val_src || rdy_src;
  assign take = load && gnt_vld;

  always_comb begin
    pop = '0;
    if (take) pop[gnt] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      val_src  <= 1'b0;
      data_src <= '0;
      id_src   <= '0;
      last_src <= 1'b0;
      rr       <= CHAN_BITS'(N_CHAN - 1);
    end else if (load) begin
      val_src <= gnt_vld;
      if (gnt_vld) begin
        data_src <= head_data[gnt];
        id_src   <= gnt;
        last_src <= head_last[gnt];
        rr       <= gnt;
      end
    end
  end

`ifdef QUEUE_STREAM_ARB_PKT_EN
  // The locked channel is always rr, so only the lock bit needs storing.
  always_ff @(posedge aclk) begin
    if (areset)    lock <= 1'b0;
    else if (take) lock <= !head_last[gnt];
  end
`endif

endmodule

// File: tb/tb_queue_stream_arb.sv
// Self-checking bench for queue_stream_arb: directed tables plus a queue-based reference model.
module tb_queue_stream_arb;
  localparam int NC = 4;
  localparam int QD = 8;
`ifdef QUEUE_STREAM_ARB_PKT_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          areset;
  logic [NC-1:0] val_snk;
  logic [NC-1:0] rdy_snk;
  logic [63:0]   data_snk [NC];
  logic [NC-1:0] last_snk;
  logic          val_src;
  logic          rdy_src;
  logic [63:0]   data_src;
  logic [1:0]    id_src;
  logic          last_src;
  logic [3:0]    cnt [NC];

  always #5 clk = ~clk;

  queue_stream_arb #(
    .QTYPE  (logic [63:0]),
    .QDEPTH (QD),
    .N_CHAN (NC)
  ) dut (
    .aclk     (clk),
    .areset   (areset),
    .val_snk  (val_snk),
    .rdy_snk  (rdy_snk),
    .data_snk (data_snk),
    .last_snk (last_snk),
    .val_src  (val_src),
    .rdy_src  (rdy_src),
    .data_src (data_src),
    .id_src   (id_src),
    .last_src (last_src),
    .cnt      (cnt)
  );

  // Reference: per-channel queues of waiting words plus one output slot.
  logic [64:0] mq [NC][$];
  bit          m_v;
  logic [63:0] m_d;
  bit          m_l;
  int          m_id;
  int          m_rr;
  bit          m_lock;
  bit          acc [NC];
  int          g;
  logic [64:0] e;

  always @(posedge clk) begin
    if (areset) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_v = 0; m_rr = NC - 1; m_lock = 0;
    end else begin
      for (int c = 0; c < NC; c++) acc[c] = val_snk[c] && (mq[c].size() < QD);
      if (!m_v || rdy_src) begin
        g = -1;
        if (PKT && m_lock) begin
          if (mq[m_rr].size() != 0) g = m_rr;
        end else begin
          for (int k = 1; k <= NC; k++)
            if (g < 0 && mq[(m_rr + k) % NC].size() != 0) g = (m_rr + k) % NC;
        end
        m_v = (g >= 0);
        if (g >= 0) begin
          e = mq[g].pop_front();
          m_d = e[63:0]; m_l = e[64]; m_id = g; m_rr = g; m_lock = !e[64];
        end
      end
      for (int c = 0; c < NC; c++) if (acc[c]) mq[c].push_back({last_snk[c], data_snk[c]});
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("model_val", 64'(val_src), 64'(m_v));
    if (m_v) begin
      chk("model_data", data_src, m_d);
      chk("model_id", 64'(id_src), 64'(m_id));
      chk("model_last", 64'(last_src), 64'(m_l));
    end
    for (int c = 0; c < NC; c++) begin
      chk("model_cnt", 64'(cnt[c]), 64'(mq[c].size()));
      chk("model_rdy", 64'(rdy_snk[c]), 64'(mq[c].size() < QD));
    end
  endtask

  task automatic idle();
    val_snk  = '0;
    last_snk = '0;
  endtask

  task automatic do_reset();
    idle();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  ch;
    logic [63:0] din;
    logic        lin;
    logic [1:0]  eid;
    logic [63:0] edat;
    logic        elast;
  } vec_t;

  vec_t       vecs [4];
  logic [1:0] got [6];
  logic [1:0] exp_ids [6];
  int         n_got;

  initial begin
    vecs[0] = '{2'd2, 64'hA5, 1'b0, 2'd2, 64'hA5, 1'b0};
    vecs[1] = '{2'd0, 64'h1234, 1'b1, 2'd0, 64'h1234, 1'b1};
    vecs[2] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[3] = '{2'd1, 64'h0, 1'b1, 2'd1, 64'h0, 1'b1};
`ifdef QUEUE_STREAM_ARB_PKT_EN
    exp_ids = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
`else
    exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif

    areset = 1'b1; rdy_src = 1'b0; idle();
    for (int c = 0; c < NC; c++) data_snk[c] = '0;
    tick(); tick();
    chk("rst_val", 64'(val_src), 64'(0));
    chk("rst_id", 64'(id_src), 64'(0));
    chk("rst_data", data_src, 64'(0));
    chk("rst_last", 64'(last_src), 64'(0));
    for (int c = 0; c < NC; c++) chk("rst_cnt", 64'(cnt[c]), 64'(0));
    areset = 1'b0;
    tick();
    chk("rst_rdy", 64'(rdy_snk), 64'hF);

    // Single words: two-edge latency and cnt returning to zero.
    rdy_src = 1'b1;
    for (int i = 0; i < 4; i++) begin
      val_snk[vecs[i].ch]  = 1'b1;
      data_snk[vecs[i].ch] = vecs[i].din;
      last_snk[vecs[i].ch] = vecs[i].lin;
      tick();
      idle();
      chk("single_early", 64'(val_src), 64'(0));
      chk("single_cnt_in", 64'(cnt[vecs[i].ch]), 64'(1));
      tick();
      chk("single_val", 64'(val_src), 64'(1));
      chk("single_data", data_src, vecs[i].edat);
      chk("single_id", 64'(id_src), 64'(vecs[i].eid));
      chk("single_last", 64'(last_src), 64'(vecs[i].elast));
      chk("single_cnt_out", 64'(cnt[vecs[i].ch]), 64'(0));
      tick();
      chk("single_done", 64'(val_src), 64'(0));
    end

    // Fill channel 0 behind a stalled output.
    rdy_src = 1'b0;
    for (int i = 0; i < 10; i++) begin
      val_snk[0] = 1'b1; data_snk[0] = 64'h100 + 64'(i); last_snk[0] = (i == 9);
      tick();
      if (i == 7) begin
        chk("fill8_cnt", 64'(cnt[0]), 64'(7));
        chk("fill8_rdy", 64'(rdy_snk[0]), 64'(1));
      end
      if (i == 8) begin
        chk("fill9_cnt", 64'(cnt[0]), 64'(8));
        chk("fill9_rdy", 64'(rdy_snk[0]), 64'(0));
      end
      if (i == 9) chk("fill10_cnt", 64'(cnt[0]), 64'(8));
    end
    chk("fill_head", data_src, 64'h100);
    idle(); rdy_src = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Fairness with all channels continuously valid.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      val_snk = 4'hF;
      for (int c = 0; c < NC; c++) data_snk[c] = 64'(c * 256 + k);
      tick();
      if (k >= 1) begin
        chk("fair_val", 64'(val_src), 64'(1));
        chk("fair_id", 64'(id_src), 64'((k - 1) % 4));
      end
    end
    idle();
    for (int i = 0; i < 40; i++) tick();

    // ch1 three-word packet alongside single-word ch0 traffic.
    do_reset();
    n_got = 0;
    for (int k = 0; k < 20; k++) begin
      if (k < 3) begin
        val_snk = 4'b0011;
        data_snk[0] = 64'(k);        last_snk[0] = 1'b1;
        data_snk[1] = 64'h10 + 64'(k); last_snk[1] = (k == 2);
      end else begin
        idle();
      end
      tick();
      if (val_src && n_got < 6) begin
        got[n_got] = id_src;
        n_got++;
      end
    end
    chk("pkt_count", 64'(n_got), 64'(6));
    for (int i = 0; i < 6; i++) chk("pkt_order", 64'(got[i]), 64'(exp_ids[i]));

    // Random traffic; first phase toggles rdy_src every cycle.
    for (int i = 0; i < 1500; i++) begin
      rdy_src  = (i < 500) ? 1'(i % 2) : 1'($urandom);
      val_snk  = 4'($urandom);
      last_snk = 4'($urandom);
      for (int c = 0; c < NC; c++) data_snk[c] = {$urandom, $urandom};
      tick();
    end
    idle(); rdy_src = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    // Reset with five words queued.
    do_reset();
    rdy_src = 1'b0;
    val_snk = 4'hF; tick();
    val_snk = 4'h1; tick();
    idle();
    areset = 1'b1;
    tick();
    chk("mid_rst_val", 64'(val_src), 64'(0));
    for (int c = 0; c < NC; c++) chk("mid_rst_cnt", 64'(cnt[c]), 64'(0));
    chk("mid_rst_rdy", 64'(rdy_snk), 64'hF);
    areset = 1'b0;
    tick();
    chk("post_rst_rdy", 64'(rdy_snk), 64'hF);
    chk("post_rst_val", 64'(val_src), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
